// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
package irq_pkg;

    localparam int NSRC_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } irqState_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered, maskable interrupt controller with fixed-priority arbitration
// and a REQ / acknowledge / release handshake towards the processor.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC-1:0]         irq_src,
    input  logic                    mask_we,
    input  logic [NSRC-1:0]         mask_wdata,
    input  logic                    ExtlAck,
    output logic                    ExtIRQ,
    output logic [$clog2(NSRC)-1:0] irq_id,
    output logic [NSRC-1:0]         pending,
    output logic [NSRC-1:0]         mask
);

    localparam int IW = $clog2(NSRC);

    irqState_t       stateReg, stateNext;
    logic [IW-1:0]   irqIdReg, irqIdNext;
    logic [NSRC-1:0] srcQ;
    logic            srcArmed;
    logic [NSRC-1:0] pendingReg, maskReg;
    logic [NSRC-1:0] riseVec, clrVec, eligible;
    logic            ackClear;
    logic            winValid;
    logic [IW-1:0]   winIdx;

    // srcArmed stays low for the first edge after reset so a line already high
    // at release is sampled into srcQ without being treated as a new edge.
    assign riseVec  = irq_src & ~srcQ & {NSRC{srcArmed}};
    assign eligible = pendingReg & maskReg;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_clr
            assign clrVec[gi] = ackClear && (irqIdReg == IW'(gi));
        end
    endgenerate

    irq_prio_enc #(
        .N  (NSRC),
        .IW (IW)
    ) u_prio (
        .req   (eligible),
        .valid (winValid),
        .idx   (winIdx)
    );

    always_comb begin
        stateNext = stateReg;
        irqIdNext = irqIdReg;
        ackClear  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (winValid) begin
                    irqIdNext = winIdx;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (ExtlAck) begin
                    ackClear  = 1'b1;
                    stateNext = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ExtlAck) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            irqIdReg   <= '0;
            srcQ       <= '0;
            srcArmed   <= 1'b0;
            pendingReg <= '0;
            maskReg    <= '1;
        end else begin
            stateReg   <= stateNext;
            irqIdReg   <= irqIdNext;
            srcQ       <= irq_src;
            srcArmed   <= 1'b1;
            // A fresh edge in the ack cycle re-sets the bit being cleared.
            pendingReg <= (pendingReg & ~clrVec) | riseVec;
            if (mask_we) begin
                maskReg <= mask_wdata;
            end
        end
    end

    assign ExtIRQ  = (stateReg == REQ);
    assign irq_id  = irqIdReg;
    assign pending = pendingReg;
    assign mask    = maskReg;

endmodule

// File: tb/tb_irq_controller.sv
// Vector table with a scoreboard queue, plus a hand sequence for reset in REQ.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_src;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ExtlAck;
    logic       ExtIRQ;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;

    int testsRun = 0;
    int testsFailed = 0;

    irq_controller #(.NSRC(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ExtlAck    (ExtlAck),
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] src;
        logic       mwe;
        logic [7:0] mdata;
        logic       ack;
        logic       ext;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] msk;
    } vec_t;

    typedef struct {
        logic       ext;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] msk;
    } exp_t;

    vec_t vq[$];
    exp_t sbq[$];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    task automatic addv(input logic [7:0] src, input logic mwe, input logic [7:0] mdata, input logic ack,
                        input logic ext, input logic [2:0] id, input logic [7:0] pend, input logic [7:0] msk);
        vec_t v;
        v.src = src; v.mwe = mwe; v.mdata = mdata; v.ack = ack;
        v.ext = ext; v.id = id; v.pend = pend; v.msk = msk;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        reset = 1'b1;
        irq_src = '0;
        mask_we = 1'b0;
        mask_wdata = '0;
        ExtlAck = 1'b0;
        #12;
        chk("reset_ext", -1, {7'd0, ExtIRQ}, 8'h00);
        chk("reset_id", -1, {5'd0, irq_id}, 8'h00);
        chk("reset_pend", -1, pending, 8'h00);
        chk("reset_mask", -1, mask, 8'hFF);
        reset = 1'b0;

        //   src  we data  ack | ext id pend mask
        addv(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
        addv(8'h08, 0, 8'h00, 0, 0, 0, 8'h08, 8'hFF);   // single source 3
        addv(8'h08, 0, 8'h00, 0, 1, 3, 8'h08, 8'hFF);
        addv(8'h08, 0, 8'h00, 1, 0, 3, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 1, 0, 3, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 3, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 3, 8'h00, 8'hFF);
        addv(8'h44, 0, 8'h00, 0, 0, 3, 8'h44, 8'hFF);   // sources 6 and 2 together
        addv(8'h44, 0, 8'h00, 0, 1, 2, 8'h44, 8'hFF);
        addv(8'h44, 0, 8'h00, 1, 0, 2, 8'h40, 8'hFF);
        addv(8'h44, 0, 8'h00, 0, 0, 2, 8'h40, 8'hFF);
        addv(8'h44, 0, 8'h00, 0, 1, 6, 8'h40, 8'hFF);
        addv(8'h44, 0, 8'h00, 1, 0, 6, 8'h00, 8'hFF);
        addv(8'h44, 0, 8'h00, 0, 0, 6, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 6, 8'h00, 8'hFF);
        addv(8'h00, 1, 8'hFE, 0, 0, 6, 8'h00, 8'hFE);   // mask source 0
        addv(8'h01, 0, 8'h00, 0, 0, 6, 8'h01, 8'hFE);
        addv(8'h01, 0, 8'h00, 0, 0, 6, 8'h01, 8'hFE);
        addv(8'h01, 1, 8'hFF, 0, 0, 6, 8'h01, 8'hFF);
        addv(8'h01, 0, 8'h00, 0, 1, 0, 8'h01, 8'hFF);
        addv(8'h01, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);
        addv(8'h02, 0, 8'h00, 1, 0, 0, 8'h02, 8'hFF);   // ack held in IDLE is ignored
        addv(8'h02, 0, 8'h00, 1, 1, 1, 8'h02, 8'hFF);
        addv(8'h02, 0, 8'h00, 1, 0, 1, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 1, 8'h00, 8'hFF);
        addv(8'h10, 0, 8'h00, 0, 0, 1, 8'h10, 8'hFF);   // collision on source 4
        addv(8'h10, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF);
        addv(8'h10, 0, 8'h00, 1, 0, 4, 8'h10, 8'hFF);
        addv(8'h10, 0, 8'h00, 0, 0, 4, 8'h10, 8'hFF);
        addv(8'h10, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF);
        addv(8'h10, 0, 8'h00, 1, 0, 4, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 4, 8'h00, 8'hFF);
        addv(8'h20, 0, 8'h00, 0, 0, 4, 8'h20, 8'hFF);   // no withdrawal during REQ
        addv(8'h20, 0, 8'h00, 0, 1, 5, 8'h20, 8'hFF);
        addv(8'h21, 1, 8'h00, 0, 1, 5, 8'h21, 8'h00);
        addv(8'h21, 0, 8'h00, 1, 0, 5, 8'h01, 8'h00);
        addv(8'h21, 0, 8'h00, 0, 0, 5, 8'h01, 8'h00);
        addv(8'h21, 0, 8'h00, 0, 0, 5, 8'h01, 8'h00);
        addv(8'h21, 1, 8'hFF, 0, 0, 5, 8'h01, 8'hFF);
        addv(8'h21, 0, 8'h00, 0, 1, 0, 8'h01, 8'hFF);
        addv(8'h21, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);
        addv(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            irq_src = v.src;
            mask_we = v.mwe;
            mask_wdata = v.mdata;
            ExtlAck = v.ack;
            e.ext = v.ext; e.id = v.id; e.pend = v.pend; e.msk = v.msk;
            sbq.push_back(e);
            step();
            e = sbq.pop_front();
            chk("ExtIRQ", i, {7'd0, ExtIRQ}, {7'd0, e.ext});
            chk("irq_id", i, {5'd0, irq_id}, {5'd0, e.id});
            chk("pending", i, pending, e.pend);
            chk("mask", i, mask, e.msk);
            $display("[TB] vec %0d src=%0h ack=%0d -> ExtIRQ=%0d id=%0d pend=%0h mask=%0h",
                     i, v.src, v.ack, ExtIRQ, irq_id, pending, mask);
        end

        // Reset asserted mid-REQ, source held high through release.
        mask_we = 1'b1;
        mask_wdata = 8'hF0;
        irq_src = 8'h00;
        ExtlAck = 1'b0;
        step();
        mask_we = 1'b0;
        irq_src = 8'h10;
        step();
        step();
        chk("pre_reset_ext", 100, {7'd0, ExtIRQ}, 8'h01);
        chk("pre_reset_id", 100, {5'd0, irq_id}, 8'h04);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ext", 101, {7'd0, ExtIRQ}, 8'h00);
        chk("async_pend", 101, pending, 8'h00);
        chk("async_mask", 101, mask, 8'hFF);
        chk("async_id", 101, {5'd0, irq_id}, 8'h00);
        step();
        #2;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("held_src_ext", 102 + c, {7'd0, ExtIRQ}, 8'h00);
            chk("held_src_pend", 102 + c, pending, 8'h00);
        end
        $display("[TB] reset-in-REQ sequence done: ExtIRQ=%0d pend=%0h", ExtIRQ, pending);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have one parameter: NSRC, default 8, number of interrupt sources (2..16).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: irq_src  input  NSRC  level interrupt lines, synchronous to clk; bit i = source i.
REQ-005 Port: mask_we  input  1  mask register write strobe.
REQ-006 Port: mask_wdata  input  NSRC  new mask value; 1 = source enabled.
REQ-007 Port: ExtlAck  input  1  processor acknowledge, level, from the processor's exception logic.
REQ-008 Port: ExtIRQ  output  1  interrupt request to the processor.
REQ-009 Port: irq_id  output  $clog2(NSRC)  index of the source being requested/serviced.
REQ-010 Port: pending  output  NSRC  pending register, unmasked view.
REQ-011 Port: mask  output  NSRC  current mask register.

Function
REQ-012 Source i SHALL be edge-triggered: pending[i] set at the edge where irq_src[i]=1 and the registered previous sample src_q[i]=0.
REQ-013 Pending bits SHALL latch regardless of mask; the mask SHALL only gate arbitration (eligible = pending & mask).
REQ-014 mask_we=1 SHALL load mask_wdata into mask at that edge.
REQ-015 Arbitration SHALL be fixed priority, lowest eligible index wins.
REQ-016 FSM states: IDLE, REQ, WAIT_REL.
REQ-017 IDLE: ExtIRQ=0; if eligible!=0, latch winner into irq_id and go to REQ.
REQ-018 REQ: ExtIRQ=1, irq_id frozen; on ExtlAck=1 clear pending[irq_id] and go to WAIT_REL.
REQ-019 WAIT_REL: ExtIRQ=0, irq_id held; on ExtlAck=0 go to IDLE.
REQ-020 Latency: edge detected at edge k -> pending set after k -> ExtIRQ=1 after edge k+1 (2 cycles from input rise).
REQ-021 ExtIRQ SHALL be driven directly from a registered state (no combinational path from any input).
REQ-022 A request in REQ SHALL NOT be withdrawn: masking or higher-priority arrivals during REQ SHALL not change ExtIRQ or irq_id.
REQ-023 A new edge on source irq_id arriving in the same cycle as its ack clear SHALL win: pending[irq_id] stays 1.
REQ-024 Further edges on an already pending source SHALL be merged (no counting).
REQ-025 If ExtlAck=1 when entering IDLE-eligible conditions, the block SHALL still wait for REQ before honouring ack; ack seen in IDLE SHALL be ignored.
REQ-026 After WAIT_REL->IDLE with eligible!=0, the next REQ SHALL follow in the next cycle (back-to-back service, min 1 idle cycle with ExtIRQ=0).

Reset
REQ-027 On reset=1 (asynchronous): state=IDLE, pending=0, src_q=0, irq_id=0, ExtIRQ=0, mask=all ones.
REQ-028 Reset asserted mid-REQ or mid-WAIT_REL SHALL drop ExtIRQ immediately and discard all pending requests.
REQ-029 A source held high across reset release SHALL NOT generate an interrupt (src_q=0 then sees 1 -> it SHALL; decided: src_q loads irq_src on first edge after release with edge detection suppressed for that one cycle).

Structure
REQ-030 Shared package irq_pkg SHALL hold the state enum (IDLE, REQ, WAIT_REL) and the NSRC default constant.
REQ-031 One sub-module irq_prio_enc (combinational lowest-index priority encoder, outputs valid + index) SHALL be instantiated.
REQ-032 Target size 120-400 lines RTL total.

Verification
REQ-033 Single: irq_src[3] rises at cycle 5 -> pending=0x08 after cycle 5, ExtIRQ=1 and irq_id=3 after cycle 6; ExtlAck=1 -> pending=0x00, ExtIRQ=0 next cycle.
REQ-034 Priority: irq_src[6] and [2] rise together -> irq_id=2 first; after ack/release, irq_id=6 serviced; pending 0x44 -> 0x40 -> 0x00.
REQ-035 Mask: mask=0xFE, irq_src[0] rises -> pending=0x01, ExtIRQ stays 0; write mask=0xFF -> ExtIRQ=1, irq_id=0 two cycles later at most.
REQ-036 Collision: new rising edge on source irq_id in the ack cycle -> pending bit remains 1, second request issued after WAIT_REL.
REQ-037 Reset mid-REQ: reset=1 while ExtIRQ=1 -> ExtIRQ=0 without clock edge, pending=0, mask=all ones; source held high through release -> no request.
